// File: rtl/stall_ctrl.sv
// Pipeline stall controller: merges ID/EX stall requests into a per-stage stop vector,
// sequences multi-cycle EX operations, and tracks stall statistics with a sticky watchdog.
module stall_ctrl (
    input  logic       clock,
    input  logic       reset,
    input  logic       stop_request_id,
    input  logic       stop_request_ex,
    input  logic       ex_multi_start,
    input  logic [1:0] ex_multi_length,
    output logic [5:0] stop_all,
    output logic [1:0] count_clock_output,
    output logic [15:0] stall_cycle_count,
    output logic       stall_timeout
);

    typedef enum logic {
        RUN   = 1'b0,
        MULTI = 1'b1
    } state_e;

    localparam logic [5:0] STOP_NONE = 6'b000000;
    localparam logic [5:0] STOP_ID   = 6'b000111;
    localparam logic [5:0] STOP_EX   = 6'b001111;

    state_e      state_q, state_d;
    logic [1:0]  remaining_q, remaining_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  watchdog_q, watchdog_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        timeout_q, timeout_d;

    logic        op_accept;
    logic        ex_stall;
    logic        pc_stalled;

    // An op is only accepted from RUN; starts seen during MULTI or with length 0 are dropped.
    assign op_accept = (state_q == RUN) && ex_multi_start && (ex_multi_length != 2'd0);
    assign ex_stall  = stop_request_ex || (state_q == MULTI) || op_accept;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        stop_all = STOP_NONE;
        if (!reset) begin
            if (ex_stall) begin
                stop_all = STOP_EX;
            end else if (stop_request_id) begin
                stop_all = STOP_ID;
            end
        end
    end

    assign pc_stalled = stop_all[0];

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        idx_d       = idx_q;
        unique case (state_q)
            RUN: begin
                if (op_accept && (ex_multi_length != 2'd1)) begin
                    state_d     = MULTI;
                    remaining_d = ex_multi_length - 2'd1;
                    idx_d       = 2'd1;
                end
            end
            MULTI: begin
                if (remaining_q == 2'd1) begin
                    state_d     = RUN;
                    remaining_d = 2'd0;
                    idx_d       = 2'd0;
                end else begin
                    remaining_d = remaining_q - 2'd1;
                    idx_d       = idx_q + 2'd1;
                end
            end
            default: begin
                state_d     = RUN;
                remaining_d = 2'd0;
                idx_d       = 2'd0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        watchdog_d  = 8'd0;
        timeout_d   = timeout_q;
        if (pc_stalled) begin
            if (stall_cnt_q != 16'hFFFF) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
            if (watchdog_q != 8'hFF) begin
                watchdog_d = watchdog_q + 8'd1;
            end else begin
                watchdog_d = watchdog_q;
            end
            // Fires exactly on the 254 -> 255 step; stays set until reset.
            if (watchdog_q == 8'd254) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q     <= RUN;
            remaining_q <= 2'd0;
            idx_q       <= 2'd0;
            watchdog_q  <= 8'd0;
            stall_cnt_q <= 16'd0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            idx_q       <= idx_d;
            watchdog_q  <= watchdog_d;
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign count_clock_output = idx_q;
    assign stall_cycle_count  = stall_cnt_q;
    assign stall_timeout      = timeout_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: directed scenarios plus random traffic,
// compared against a queue-based behavioural model of the stall rules.
module tb_stall_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        stop_request_id;
    logic        stop_request_ex;
    logic        ex_multi_start;
    logic [1:0]  ex_multi_length;
    logic [5:0]  stop_all;
    logic [1:0]  count_clock_output;
    logic [15:0] stall_cycle_count;
    logic        stall_timeout;

    int checks   = 0;
    int failures = 0;

    // Model: pending MULTI-cycle indices still to be played, plus plain integer statistics.
    int m_pending[$];
    int m_stalls    = 0;
    int m_run       = 0;
    bit m_timeout   = 1'b0;

    always #5 clock = ~clock;

    stall_ctrl dut (
        .clock              (clock),
        .reset              (reset),
        .stop_request_id    (stop_request_id),
        .stop_request_ex    (stop_request_ex),
        .ex_multi_start     (ex_multi_start),
        .ex_multi_length    (ex_multi_length),
        .stop_all           (stop_all),
        .count_clock_output (count_clock_output),
        .stall_cycle_count  (stall_cycle_count),
        .stall_timeout      (stall_timeout)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs just after a rising edge, check on the falling edge,
    // then advance the model to what the next rising edge should produce.
    task automatic cycle(input string tag, input bit rst, input bit id, input bit ex,
                         input bit st, input int len);
        bit       in_op;
        bit       accept;
        logic [5:0] exp_sa;
        int       exp_idx;
        reset           = rst;
        stop_request_id = id;
        stop_request_ex = ex;
        ex_multi_start  = st;
        ex_multi_length = 2'(len);
        @(negedge clock);
        in_op   = (m_pending.size() != 0);
        accept  = !in_op && st && (len != 0);
        exp_idx = in_op ? m_pending[0] : 0;
        if (rst)                        exp_sa = 6'b000000;
        else if (ex || in_op || accept) exp_sa = 6'b001111;
        else if (id)                    exp_sa = 6'b000111;
        else                            exp_sa = 6'b000000;
        check({tag, ".stop_all"}, 16'(stop_all), 16'(exp_sa));
        check({tag, ".cco"}, 16'(count_clock_output), 16'(exp_idx));
        check({tag, ".count"}, stall_cycle_count, 16'(m_stalls));
        check({tag, ".timeout"}, 16'(stall_timeout), 16'(m_timeout));
        if (rst) begin
            m_pending.delete();
            m_stalls  = 0;
            m_run     = 0;
            m_timeout = 1'b0;
        end else begin
            if (in_op) begin
                void'(m_pending.pop_front());
            end else if (accept) begin
                for (int i = 1; i < len; i++) m_pending.push_back(i);
            end
            if (exp_sa[0]) begin
                if (m_stalls < 65535) m_stalls++;
                m_run++;
                if (m_run == 255) m_timeout = 1'b1;
            end else begin
                m_run = 0;
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; stop_request_id = 1'b0; stop_request_ex = 1'b0;
        ex_multi_start = 1'b0; ex_multi_length = 2'd0;
        @(posedge clock);
        #1;

        // Reset for two cycles with quiet inputs, then one idle cycle.
        cycle("reset0", 1, 0, 0, 0, 0);
        cycle("reset1", 1, 0, 0, 0, 0);
        cycle("idle", 0, 0, 0, 0, 0);

        // Single ID request.
        cycle("id_pulse", 0, 1, 0, 0, 0);
        cycle("id_after", 0, 0, 0, 0, 0);
        check("id_count", stall_cycle_count, 16'd1);

        // Length-3 op: three EX stall cycles with indices 0,1,2.
        cycle("len3_c0", 0, 0, 0, 1, 3);
        cycle("len3_c1", 0, 0, 0, 0, 0);
        cycle("len3_c2", 0, 0, 0, 0, 0);
        cycle("len3_done", 0, 0, 0, 0, 0);
        check("len3_count", stall_cycle_count, 16'd4);

        // Length-2 op with simultaneous ID request: EX wins, then ID alone.
        cycle("len2_id_c0", 0, 1, 0, 1, 2);
        cycle("len2_id_c1", 0, 1, 0, 0, 0);
        cycle("id_only", 0, 1, 0, 0, 0);
        cycle("idle2", 0, 0, 0, 0, 0);

        // Length 1, length 0 (ignored), start during MULTI (ignored), EX level across MULTI.
        cycle("len1", 0, 0, 0, 1, 1);
        cycle("len1_after", 0, 0, 0, 0, 0);
        cycle("len0", 0, 0, 0, 1, 0);
        cycle("len3b_c0", 0, 0, 0, 1, 3);
        cycle("len3b_c1_st", 0, 0, 1, 1, 2);
        cycle("len3b_c2_ex", 0, 0, 1, 0, 0);
        cycle("ex_after_op", 0, 0, 1, 0, 0);
        cycle("idle3", 0, 0, 0, 0, 0);

        // Watchdog: EX held 300 cycles from a fresh reset.
        cycle("wd_reset", 1, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) cycle("wd_hold", 0, 0, 1, 0, 0);
        cycle("wd_release", 0, 0, 0, 0, 0);
        cycle("wd_release2", 0, 0, 0, 0, 0);
        check("wd_sticky", 16'(stall_timeout), 16'd1);
        check("wd_count", stall_cycle_count, 16'd300);

        // Reset asserted while a length-3 op is at index 1.
        cycle("abort_start", 0, 0, 0, 1, 3);
        cycle("abort_rst", 1, 0, 0, 0, 0);
        cycle("abort_after", 0, 0, 0, 0, 0);
        check("abort_cco", 16'(count_clock_output), 16'd0);
        check("abort_timeout", 16'(stall_timeout), 16'd0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            cycle("rand",
                  ($urandom_range(0, 99) < 2),
                  ($urandom_range(0, 99) < 30),
                  ($urandom_range(0, 99) < 15),
                  ($urandom_range(0, 99) < 25),
                  int'($urandom_range(0, 3)));
        end
        // Long stall burst so the timeout path is also exercised from random state.
        for (int i = 0; i < 260; i++) begin
            cycle("rand_burst", 0, $urandom_range(0, 1), 1, $urandom_range(0, 1),
                  int'($urandom_range(0, 3)));
        end
        for (int i = 0; i < 40; i++) begin
            cycle("rand_tail", 0, ($urandom_range(0, 99) < 30), 0,
                  ($urandom_range(0, 99) < 25), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
